cover_toggle_scheduler: RTL and testbench

- Sits between a toggle-coverage point vector and a reporting channel that accepts one cover index per cycle. The channel is a DPI sink in simulation and a trace/counter port in formal/FPGA builds.
- Captures every asserted bit of a wide per-cycle valid vector into sticky pending state, optionally filters repeats, and serialises the bits one per cycle as absolute cover indices.
- Uses round-robin arbitration over a valid/ready handshake.

---
 rtl/cover_toggle_scheduler.sv | 138 +++++++++++++
 tb/tb_cover_toggle_scheduler.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cover_toggle_scheduler.sv
// Serialises a wide per-cycle cover-event vector into one absolute cover index
// per cycle, with sticky pending capture, optional repeat filtering and round-robin fairness.
module cover_toggle_scheduler #(
  parameter int              WIDTH       = 58,
  parameter longint unsigned COVER_INDEX = 64'd0,
  parameter bit              ONCE_ONLY   = 1'b1,
  parameter int              CNT_W       = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  valid,
  input  logic              clear,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [63:0]       out_index,
  output logic              busy,
  output logic [CNT_W-1:0]  hit_count
);

  localparam int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] acc;
    acc = {CNT_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      acc = acc + CNT_W'(v[i]);
    end
    return acc;
  endfunction

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   pending_q, pending_d;
  logic [WIDTH-1:0]   covered_q, covered_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [63:0]        out_index_q, out_index_d;
  logic [CNT_W-1:0]   hit_count_q, hit_count_d;
  logic               busy_q, busy_d;

  logic               hi_found, lo_found;
  logic [PTR_W-1:0]   hi_idx, lo_idx, win_idx;
  logic               any_pending;
  logic               slot_free, load_en;
  logic [WIDTH-1:0]   load_mask, covered_loaded, capture_mask;

  // Round-robin winner: lowest pending bit at or above rr_ptr, else lowest overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = {PTR_W{1'b0}};
    lo_idx   = {PTR_W{1'b0}};
    for (int i = WIDTH - 1; i >= 0; i--) begin
      lo_found = pending_q[i] ? 1'b1 : lo_found;
      lo_idx   = pending_q[i] ? PTR_W'(i) : lo_idx;
      hi_found = (pending_q[i] && (i >= int'(rr_ptr_q))) ? 1'b1 : hi_found;
      hi_idx   = (pending_q[i] && (i >= int'(rr_ptr_q))) ? PTR_W'(i) : hi_idx;
    end
    win_idx     = hi_found ? hi_idx : lo_idx;
    any_pending = lo_found;
  end

  // Slot FSM, load, capture and clear next-state.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    out_index_d = out_index_q;
    load_mask   = {WIDTH{1'b0}};

    slot_free = (state_q == S_EMPTY) || out_ready;
    load_en   = slot_free && any_pending && !clear;

    case (state_q)
      S_EMPTY: state_d = load_en ? S_FULL : S_EMPTY;
      S_FULL: begin
        if (out_ready) begin
          state_d = load_en ? S_FULL : S_EMPTY;
        end else begin
          state_d = S_FULL;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    if (load_en) begin
      load_mask   = {{(WIDTH-1){1'b0}}, 1'b1} << win_idx;
      out_index_d = COVER_INDEX + 64'(win_idx);
      rr_ptr_d    = (win_idx == PTR_W'(WIDTH - 1)) ? {PTR_W{1'b0}} : win_idx + PTR_W'(1);
    end else begin
      load_mask   = {WIDTH{1'b0}};
    end

    // A hit landing on the bit being loaded is filtered against the post-load covered map.
    covered_loaded = covered_q | load_mask;
    capture_mask   = valid & ~({WIDTH{ONCE_ONLY}} & covered_loaded);

    if (clear) begin
      pending_d = {WIDTH{1'b0}};
      covered_d = {WIDTH{1'b0}};
    end else begin
      pending_d = (pending_q & ~load_mask) | capture_mask;
      covered_d = covered_loaded;
    end

    hit_count_d = popcount(covered_d);
    busy_d      = (state_d == S_FULL) || (|pending_d);
  end

  // State registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_EMPTY;
      pending_q   <= {WIDTH{1'b0}};
      covered_q   <= {WIDTH{1'b0}};
      rr_ptr_q    <= {PTR_W{1'b0}};
      out_index_q <= 64'd0;
      hit_count_q <= {CNT_W{1'b0}};
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      covered_q   <= covered_d;
      rr_ptr_q    <= rr_ptr_d;
      out_index_q <= out_index_d;
      hit_count_q <= hit_count_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = (state_q == S_FULL);
  assign out_index = out_index_q;
  assign busy      = busy_q;
  assign hit_count = hit_count_q;

endmodule

// File: tb/tb_cover_toggle_scheduler.sv
// Bench for cover_toggle_scheduler: two instances (repeat-reporting and once-only)
// driven by shared stimulus and checked against an abstract pending/covered model.
module tb_cover_toggle_scheduler;

  localparam int              W  = 58;
  localparam longint unsigned CI = 64'd100;
  localparam int              CW = 7;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [W-1:0]  valid = '0;
  logic          clear = 1'b0;
  logic          out_ready = 1'b1;

  logic          ov [2];
  logic [63:0]   oi [2];
  logic          bz [2];
  logic [CW-1:0] hc [2];

  cover_toggle_scheduler #(.WIDTH(W), .COVER_INDEX(CI), .ONCE_ONLY(1'b0), .CNT_W(CW)) dut0 (
    .clock(clock), .reset(reset), .valid(valid), .clear(clear), .out_ready(out_ready),
    .out_valid(ov[0]), .out_index(oi[0]), .busy(bz[0]), .hit_count(hc[0])
  );

  cover_toggle_scheduler #(.WIDTH(W), .COVER_INDEX(CI), .ONCE_ONLY(1'b1), .CNT_W(CW)) dut1 (
    .clock(clock), .reset(reset), .valid(valid), .clear(clear), .out_ready(out_ready),
    .out_valid(ov[1]), .out_index(oi[1]), .busy(bz[1]), .hit_count(hc[1])
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Model: set of pending points, set of covered points, fairness pointer, presented slot.
  logic [W-1:0]    m_pend [2];
  logic [W-1:0]    m_cov  [2];
  int              m_ptr  [2];
  bit              m_full [2];
  longint unsigned m_idx  [2];
  longint unsigned acc    [2][$];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pend[d] = '0;
      m_cov[d]  = '0;
      m_ptr[d]  = 0;
      m_full[d] = 1'b0;
      m_idx[d]  = 64'd0;
    end
  endtask

  task automatic model_step();
    bit once;
    int w;
    for (int d = 0; d < 2; d++) begin
      once = (d == 1);
      if (clear) begin
        if (m_full[d] && out_ready) m_full[d] = 1'b0;
        m_pend[d] = '0;
        m_cov[d]  = '0;
      end else begin
        if ((!m_full[d] || out_ready) && (m_pend[d] != '0)) begin
          w = -1;
          for (int k = 0; k < W; k++) begin
            if (w < 0 && m_pend[d][(m_ptr[d] + k) % W]) w = (m_ptr[d] + k) % W;
          end
          m_pend[d][w] = 1'b0;
          m_cov[d][w]  = 1'b1;
          m_idx[d]     = CI + longint'(w);
          m_ptr[d]     = (w + 1) % W;
          m_full[d]    = 1'b1;
        end else if (m_full[d] && out_ready) begin
          m_full[d] = 1'b0;
        end
        for (int i = 0; i < W; i++) begin
          if (valid[i] && !(once && m_cov[d][i])) m_pend[d][i] = 1'b1;
        end
      end
    end
  endtask

  // One clock: log accepted beats, advance the model on the edge, settle.
  task automatic tick();
    for (int d = 0; d < 2; d++) begin
      if (ov[d] && out_ready) acc[d].push_back(oi[d]);
    end
    @(posedge clock);
    if (!reset) model_reset();
    else model_step();
    #1;
  endtask

  task automatic clear_logs();
    acc[0].delete();
    acc[1].delete();
  endtask

  task automatic do_reset();
    valid = '0; clear = 1'b0; out_ready = 1'b1;
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    clear_logs();
  endtask

  task automatic test_reset();
    reset = 1'b0; valid = '1; clear = 1'b0; out_ready = 1'b1;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (ov[d] !== 1'b0 || bz[d] !== 1'b0 || hc[d] !== 7'd0 || oi[d] !== 64'd0) begin
          n_err++;
          $display("FAIL reset_hold dut%0d: got valid=%0b busy=%0b hits=%0d idx=%0d want 0/0/0/0",
                   d, ov[d], bz[d], hc[d], oi[d]);
        end
      end
    end
    reset = 1'b1; valid = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (ov[d] !== 1'b0 || bz[d] !== 1'b0) begin
          n_err++;
          $display("FAIL reset_release dut%0d: got valid=%0b busy=%0b want 0/0", d, ov[d], bz[d]);
        end
      end
    end
    clear_logs();
  endtask

  task automatic test_single_hit();
    out_ready = 1'b1;
    valid = '0; valid[5] = 1'b1;
    tick();
    valid = '0;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (ov[d] !== 1'b0 || bz[d] !== 1'b1) begin
        n_err++;
        $display("FAIL single_capture dut%0d: got valid=%0b busy=%0b want 0/1", d, ov[d], bz[d]);
      end
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (ov[d] !== 1'b1 || oi[d] !== 64'd105) begin
        n_err++;
        $display("FAIL single_beat dut%0d: got valid=%0b idx=%0d want 1/105", d, ov[d], oi[d]);
      end
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (ov[d] !== 1'b0 || hc[d] !== 7'd1 || bz[d] !== 1'b0) begin
        n_err++;
        $display("FAIL single_done dut%0d: got valid=%0b hits=%0d busy=%0b want 0/1/0",
                 d, ov[d], hc[d], bz[d]);
      end
    end
  endtask

  task automatic check_sweep(input string name);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (acc[d].size() != W) begin
        n_err++;
        $display("FAIL %s_count dut%0d: got %0d beats want %0d", name, d, acc[d].size(), W);
      end else begin
        for (int k = 0; k < W; k++) begin
          n_cmp++;
          if (acc[d][k] !== CI + longint'(k)) begin
            n_err++;
            $display("FAIL %s_order dut%0d beat %0d: got %0d want %0d", name, d, k, acc[d][k], CI + k);
          end
        end
      end
      n_cmp++;
      if (hc[d] !== CW'(W)) begin
        n_err++;
        $display("FAIL %s_hits dut%0d: got %0d want %0d", name, d, hc[d], W);
      end
    end
  endtask

  task automatic test_burst();
    int first_c [2];
    int last_c  [2];
    do_reset();
    first_c[0] = -1; first_c[1] = -1; last_c[0] = -1; last_c[1] = -1;
    valid = '1;
    tick();
    valid = '0;
    for (int c = 0; c < 70; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        if (ov[d]) begin
          if (first_c[d] < 0) first_c[d] = c;
          last_c[d] = c;
        end
      end
    end
    check_sweep("burst");
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (first_c[d] != 0 || last_c[d] - first_c[d] + 1 != W) begin
        n_err++;
        $display("FAIL burst_bubbles dut%0d: got span %0d..%0d want 0..%0d", d, first_c[d], last_c[d], W - 1);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    valid = '1; out_ready = 1'b1;
    tick();
    valid = '0; out_ready = 1'b0;
    for (int c = 0; c < 11; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (ov[d] !== 1'b1 || oi[d] !== 64'd100) begin
          n_err++;
          $display("FAIL stall_hold dut%0d cyc %0d: got valid=%0b idx=%0d want 1/100", d, c, ov[d], oi[d]);
        end
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 70; c++) tick();
    check_sweep("stall");
  endtask

  task automatic test_filter();
    do_reset();
    for (int p = 0; p < 2; p++) begin
      valid = '0; valid[5] = 1'b1;
      tick();
      valid = '0;
      for (int c = 0; c < 10; c++) tick();
    end
    n_cmp++;
    if (acc[1].size() != 1 || acc[1][0] !== 64'd105) begin
      n_err++;
      $display("FAIL filter_once: got %0d beats (first %0d) want 1 beat 105",
               acc[1].size(), acc[1].size() > 0 ? acc[1][0] : 64'd0);
    end
    n_cmp++;
    if (acc[0].size() != 2 || acc[0][0] !== 64'd105 || acc[0][1] !== 64'd105) begin
      n_err++;
      $display("FAIL filter_repeat: got %0d beats want 2 beats of 105", acc[0].size());
    end
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (hc[d] !== 7'd1) begin
        n_err++;
        $display("FAIL filter_hits dut%0d: got %0d want 1", d, hc[d]);
      end
    end
  endtask

  task automatic test_fairness();
    do_reset();
    valid = '0; valid[0] = 1'b1; valid[1] = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    valid = '0;
    for (int c = 0; c < 5; c++) tick();
    n_cmp++;
    if (acc[0].size() < 18) begin
      n_err++;
      $display("FAIL fair_count: got %0d beats want at least 18", acc[0].size());
    end
    for (int k = 0; k < acc[0].size(); k++) begin
      n_cmp++;
      if (acc[0][k] !== CI + longint'(k % 2)) begin
        n_err++;
        $display("FAIL fair_order beat %0d: got %0d want %0d", k, acc[0][k], CI + (k % 2));
      end
    end
    n_cmp++;
    if (acc[1].size() != 2 || acc[1][0] !== 64'd100 || acc[1][1] !== 64'd101) begin
      n_err++;
      $display("FAIL fair_once: got %0d beats want 100,101", acc[1].size());
    end
  endtask

  task automatic test_clear();
    do_reset();
    valid = '0; valid[5] = 1'b1;
    tick();
    valid = '0;
    for (int c = 0; c < 5; c++) tick();
    n_cmp++;
    if (hc[1] !== 7'd1) begin
      n_err++;
      $display("FAIL clear_pre_hits: got %0d want 1", hc[1]);
    end
    clear = 1'b1; valid[5] = 1'b1;
    tick();
    clear = 1'b0; valid = '0;
    clear_logs();
    for (int c = 0; c < 5; c++) tick();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (acc[d].size() != 0 || hc[d] !== 7'd0 || ov[d] !== 1'b0) begin
        n_err++;
        $display("FAIL clear_drop dut%0d: got beats=%0d hits=%0d valid=%0b want 0/0/0",
                 d, acc[d].size(), hc[d], ov[d]);
      end
    end
    valid[5] = 1'b1;
    tick();
    valid = '0;
    for (int c = 0; c < 5; c++) tick();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (acc[d].size() != 1 || acc[d][0] !== 64'd105 || hc[d] !== 7'd1) begin
        n_err++;
        $display("FAIL clear_rehit dut%0d: got beats=%0d hits=%0d want 1 beat 105, hits 1",
                 d, acc[d].size(), hc[d]);
      end
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      reset = 1'b1;
      valid = '0;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        valid = '1;
      end else if (r < 45) begin
        for (int k = 0; k < 3; k++) valid[$urandom_range(0, W - 1)] = 1'b1;
      end
      clear     = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 149) == 0) begin
        reset = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
          n_cmp++;
          if (ov[d] !== 1'b0 || bz[d] !== 1'b0 || hc[d] !== 7'd0) begin
            n_err++;
            $display("FAIL rand_async_reset dut%0d: got valid=%0b busy=%0b hits=%0d want 0/0/0",
                     d, ov[d], bz[d], hc[d]);
          end
        end
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (ov[d] !== m_full[d] || oi[d] !== m_idx[d] ||
            hc[d] !== CW'($countones(m_cov[d])) || bz[d] !== (m_full[d] || (m_pend[d] != '0))) begin
          n_err++;
          $display("FAIL rand_model dut%0d cyc %0d: got v=%0b i=%0d h=%0d b=%0b want v=%0b i=%0d h=%0d b=%0b",
                   d, c, ov[d], oi[d], hc[d], bz[d], m_full[d], m_idx[d],
                   $countones(m_cov[d]), (m_full[d] || (m_pend[d] != '0)));
        end
      end
    end
    reset = 1'b1; valid = '0; clear = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_burst();
    test_backpressure();
    test_filter();
    test_fairness();
    test_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
